// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing a 2-bit 4:1 select datapath among four requesters,
// with a registered valid/ready output and a one-cycle ack. Define MUX_SCHED_CNT_EN to add grant_cnt.
module mux_rr_scheduler #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [1:0]       U,
  input  logic [1:0]       V,
  input  logic [1:0]       W,
  input  logic [1:0]       X,
  input  logic             out_ready,
  output logic [1:0]       M,
  output logic             out_valid,
  output logic [1:0]       S,
  output logic [3:0]       ack,
  output logic             busy,
`ifdef MUX_SCHED_CNT_EN
  output logic [4*CNT_W-1:0] grant_cnt,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: M is transferred on any rising edge where out_valid && out_ready;
  // once out_valid is high, M and S stay frozen until that edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] m_q, m_d;
  logic [1:0] s_q, s_d;
  logic [1:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic [3:0] ack_q, ack_d;
  logic [3:0] gap_q, gap_d;

  logic       found;
  logic [1:0] grant;
  logic [1:0] idx;
  logic [1:0] sel_word;
  logic       accept;

  // First asserted request at or after ptr_q, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    grant = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    case (grant)
      2'd0:    sel_word = U;
      2'd1:    sel_word = V;
      2'd2:    sel_word = W;
      default: sel_word = X;
    endcase
  end

  assign accept = (state_q == ST_BUSY) && valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    ack_d   = 4'b0000;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          s_d     = grant;
          m_d     = sel_word;
          valid_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          valid_d = 1'b0;
          ack_d   = 4'b0001 << s_q;
          ptr_d   = s_q + 2'd1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = 4'(GAP_CYCLES);
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= 2'b00;
      s_q     <= 2'b00;
      ptr_q   <= 2'b00;
      valid_q <= 1'b0;
      ack_q   <= 4'b0000;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      gap_q   <= gap_d;
    end
  end

  assign M         = m_q;
  assign S         = s_q;
  assign out_valid = valid_q;
  assign ack       = ack_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // Counter width must be at least one bit.
  if (CNT_W < 1) begin : g_bad_cnt_w
  end

`ifdef MUX_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  // Saturating per-source counters, bumped on the same edge that raises ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[s_q] != {CNT_W{1'b1}})) begin
      cnt_q[s_q] <= cnt_q[s_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
